// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, one instruction in flight.
// Strobes are combinational from state+IR; memory waits hold the state until mem_ready or timeout.
module mips_multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      instr,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_b,
  output logic             ext_zero,
  output logic [3:0]       alu_ctrl,
  output logic [2:0]       state,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_ADDU = 4'b1011;
  localparam logic [3:0] ALU_SUBU = 4'b1100;

  state_t           cur, nxt;
  logic [TMO_W-1:0] wcnt;
  logic             tmo_hit, retire, set_illegal;

  logic [5:0] op, funct;
  logic [4:0] rt, rd;
  logic       dec_legal, is_r, is_j, is_jal, is_jr, is_beq, is_bne, is_lw, is_sw;
  logic       dec_imm, dec_zext;
  logic [3:0] dec_alu;
  logic       unused_fields;

  assign op    = instr[31:26];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign funct = instr[5:0];
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  always_comb begin
    dec_legal = 1'b1;
    is_r = 1'b0; is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0;
    is_beq = 1'b0; is_bne = 1'b0; is_lw = 1'b0; is_sw = 1'b0;
    dec_imm = 1'b1; dec_zext = 1'b0; dec_alu = ALU_ADD;
    case (op)
      6'h00: begin
        is_r    = 1'b1;
        dec_imm = 1'b0;
        case (funct)
          6'h00: dec_alu = ALU_SLL;
          6'h02: dec_alu = ALU_SRL;
          6'h03: dec_alu = ALU_SRA;
          6'h08: is_jr   = 1'b1;
          6'h20: dec_alu = ALU_ADD;
          6'h21: dec_alu = ALU_ADDU;
          6'h22: dec_alu = ALU_SUB;
          6'h23: dec_alu = ALU_SUBU;
          6'h24: dec_alu = ALU_AND;
          6'h25: dec_alu = ALU_OR;
          6'h26: dec_alu = ALU_XOR;
          6'h27: dec_alu = ALU_NOR;
          6'h2A: dec_alu = ALU_SLT;
          default: dec_legal = 1'b0;
        endcase
      end
      6'h02: is_j   = 1'b1;
      6'h03: is_jal = 1'b1;
      6'h04: begin is_beq = 1'b1; dec_imm = 1'b0; dec_alu = ALU_SUB; end
      6'h05: begin is_bne = 1'b1; dec_imm = 1'b0; dec_alu = ALU_SUB; end
      6'h08: dec_alu = ALU_ADD;
      6'h09: dec_alu = ALU_ADDU;
      6'h0A: dec_alu = ALU_SLT;
      6'h0C: begin dec_alu = ALU_AND; dec_zext = 1'b1; end
      6'h0D: begin dec_alu = ALU_OR;  dec_zext = 1'b1; end
      6'h0E: begin dec_alu = ALU_XOR; dec_zext = 1'b1; end
      6'h23: is_lw = 1'b1;
      6'h2B: is_sw = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  // A response is still accepted in wait cycle MEM_TIMEOUT; only its absence there traps.
  assign tmo_hit = (MEM_TIMEOUT != 0) && (wcnt == TMO_W'(MEM_TIMEOUT));

  always_comb begin
    nxt = cur;
    retire = 1'b0; set_illegal = 1'b0;
    imem_req = 1'b0; dmem_req = 1'b0; dmem_we = 1'b0;
    ir_we = 1'b0; pc_we = 1'b0; pc_src = 2'b00;
    reg_we = 1'b0; reg_dst = 2'b00; mem_to_reg = 2'b00;
    alu_src_b = 1'b0; ext_zero = 1'b0; alu_ctrl = 4'b0000;
    case (cur)
      S_IDLE: if (start) nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          nxt   = S_DECODE;
        end else if (tmo_hit) begin
          nxt = S_ERROR;
        end
      end
      S_DECODE: begin
        if (!dec_legal) begin
          nxt = S_ERROR;
          set_illegal = 1'b1;
        end else if (is_j || is_jal) begin
          pc_we = 1'b1; pc_src = 2'b10; retire = 1'b1; nxt = S_FETCH;
          if (is_jal) begin
            reg_we = 1'b1; reg_dst = 2'b10; mem_to_reg = 2'b10;
          end
        end else if (is_jr) begin
          pc_we = 1'b1; pc_src = 2'b11; retire = 1'b1; nxt = S_FETCH;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_ctrl = dec_alu; alu_src_b = dec_imm; ext_zero = dec_zext;
        if (is_beq || is_bne) begin
          pc_src = 2'b01;
          pc_we  = is_beq ? alu_zero : !alu_zero;
          retire = 1'b1;
          nxt    = S_FETCH;
        end else if (is_lw || is_sw) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        alu_ctrl = dec_alu; alu_src_b = dec_imm; ext_zero = dec_zext;
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        if (mem_ready) begin
          if (is_sw) begin
            retire = 1'b1; nxt = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end else if (tmo_hit) begin
          nxt = S_ERROR;
        end
      end
      S_WB: begin
        alu_ctrl = dec_alu; alu_src_b = dec_imm; ext_zero = dec_zext;
        reg_dst    = is_r ? 2'b01 : 2'b00;
        mem_to_reg = is_lw ? 2'b01 : 2'b00;
        reg_we     = is_r ? (rd != 5'd0) : (rt != 5'd0);
        retire     = 1'b1;
        nxt        = S_FETCH;
      end
      S_ERROR: nxt = S_ERROR;
      default: nxt = S_ERROR;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= S_IDLE;
      instr_count <= '0;
      illegal     <= 1'b0;
      wcnt        <= '0;
    end else begin
      cur <= nxt;
      if (retire) instr_count <= instr_count + CNT_W'(1);
      if (set_illegal) illegal <= 1'b1;
      if (nxt != cur) wcnt <= '0;
      else if ((MEM_TIMEOUT != 0) && (cur == S_FETCH || cur == S_MEM)) wcnt <= wcnt + TMO_W'(1);
    end
  end

  assign state = cur;
  assign busy  = (cur == S_FETCH) || (cur == S_DECODE) || (cur == S_EXEC) ||
                 (cur == S_MEM) || (cur == S_WB);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-scenario tasks with hand-computed expectations.
module tb_mips_multicycle_ctrl;
  logic        clock, rst_n, start, alu_zero, mem_ready;
  logic [31:0] instr;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, alu_src_b, ext_zero, busy, illegal;
  logic [1:0]  pc_src, reg_dst, mem_to_reg;
  logic [3:0]  alu_ctrl;
  logic [2:0]  state;
  logic [31:0] instr_count;
  int checks = 0;
  int passed = 0;

  localparam logic [31:0] I_ADD  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] I_LW   = {6'h23, 5'd1, 5'd4, 16'd8};
  localparam logic [31:0] I_SW   = {6'h2B, 5'd1, 5'd4, 16'd8};
  localparam logic [31:0] I_BEQ  = {6'h04, 5'd1, 5'd2, 16'd4};
  localparam logic [31:0] I_JAL  = {6'h03, 26'd16};
  localparam logic [31:0] I_JR   = {6'h00, 5'd31, 15'd0, 6'h08};
  localparam logic [31:0] I_ADDI = {6'h08, 5'd1, 5'd0, 16'd5};
  localparam logic [31:0] I_ORI  = {6'h0D, 5'd1, 5'd5, 16'h00FF};
  localparam logic [31:0] I_BAD  = {6'h3F, 26'd0};

  mips_multicycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(15), .TMO_W(4)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .instr(instr), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .ext_zero(ext_zero), .alu_ctrl(alu_ctrl),
    .state(state), .busy(busy), .illegal(illegal), .instr_count(instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0; instr = I_ADD;
    #2;
    checks++; if ({state, busy, illegal, imem_req, dmem_req, pc_we, reg_we} !== {3'd0, 6'b0})
      $display("FAIL reset_outputs: state=%0d busy=%b illegal=%b imem=%b", state, busy, illegal, imem_req);
    else passed++;
    checks++; if (instr_count !== 32'd0) $display("FAIL reset_count: got %0d want 0", instr_count); else passed++;
    #10 rst_n = 1'b1;
    tick();
  endtask

  // Leaves the FSM in FETCH with mem_ready low.
  task automatic test_add();
    instr = I_ADD; mem_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    checks++; if ({state, imem_req, ir_we, pc_we, pc_src} !== {3'd1, 3'b111, 2'b00})
      $display("FAIL add_fetch: state=%0d imem=%b ir_we=%b pc_we=%b pc_src=%b", state, imem_req, ir_we, pc_we, pc_src);
    else passed++;
    tick();
    checks++; if (state !== 3'd2) $display("FAIL add_decode: state=%0d want 2", state); else passed++;
    tick();
    checks++; if ({state, alu_ctrl, alu_src_b} !== {3'd3, 4'b0010, 1'b0})
      $display("FAIL add_exec: state=%0d alu=%b srcb=%b", state, alu_ctrl, alu_src_b);
    else passed++;
    tick();
    checks++; if ({state, reg_we, reg_dst, alu_ctrl, mem_to_reg} !== {3'd5, 1'b1, 2'b01, 4'b0010, 2'b00})
      $display("FAIL add_wb: state=%0d reg_we=%b dst=%b alu=%b m2r=%b", state, reg_we, reg_dst, alu_ctrl, mem_to_reg);
    else passed++;
    tick(); mem_ready = 1'b0;
    checks++; if ({state, instr_count} !== {3'd1, 32'd1}) $display("FAIL add_retire: state=%0d count=%0d", state, instr_count); else passed++;
  endtask

  task automatic test_lw();
    instr = I_LW; mem_ready = 1'b1;
    tick(); tick();
    checks++; if ({state, alu_ctrl, alu_src_b, ext_zero} !== {3'd3, 4'b0010, 1'b1, 1'b0})
      $display("FAIL lw_exec: state=%0d alu=%b srcb=%b zext=%b", state, alu_ctrl, alu_src_b, ext_zero);
    else passed++;
    tick();
    checks++; if ({state, dmem_req, dmem_we, reg_we} !== {3'd4, 3'b100})
      $display("FAIL lw_mem: state=%0d dreq=%b dwe=%b reg_we=%b", state, dmem_req, dmem_we, reg_we);
    else passed++;
    tick();
    checks++; if ({state, reg_we, reg_dst, mem_to_reg} !== {3'd5, 1'b1, 2'b00, 2'b01})
      $display("FAIL lw_wb: state=%0d reg_we=%b dst=%b m2r=%b", state, reg_we, reg_dst, mem_to_reg);
    else passed++;
    tick(); mem_ready = 1'b0;
    checks++; if ({state, instr_count} !== {3'd1, 32'd2}) $display("FAIL lw_retire: state=%0d count=%0d", state, instr_count); else passed++;
  endtask

  task automatic test_beq();
    for (int taken = 1; taken >= 0; taken--) begin
      instr = I_BEQ; mem_ready = 1'b1;
      tick(); mem_ready = 1'b0;
      tick(); alu_zero = (taken == 1); #1;
      checks++; if ({state, pc_we, pc_src, alu_ctrl} !== {3'd3, (taken == 1), 2'b01, 4'b0110})
        $display("FAIL beq_exec_%0d: state=%0d pc_we=%b pc_src=%b alu=%b", taken, state, pc_we, pc_src, alu_ctrl);
      else passed++;
      tick(); alu_zero = 1'b0;
      checks++; if ({state, instr_count} !== {3'd1, (taken == 1) ? 32'd3 : 32'd4})
        $display("FAIL beq_retire_%0d: state=%0d count=%0d", taken, state, instr_count);
      else passed++;
    end
  endtask

  task automatic test_jumps();
    instr = I_JAL; mem_ready = 1'b1; start = 1'b1;
    tick(); mem_ready = 1'b0;
    checks++; if ({state, pc_we, pc_src, reg_we, reg_dst, mem_to_reg} !== {3'd2, 1'b1, 2'b10, 1'b1, 2'b10, 2'b10})
      $display("FAIL jal_decode: state=%0d pc_we=%b pc_src=%b reg_we=%b dst=%b m2r=%b", state, pc_we, pc_src, reg_we, reg_dst, mem_to_reg);
    else passed++;
    tick(); start = 1'b0;
    checks++; if ({state, instr_count} !== {3'd1, 32'd5}) $display("FAIL jal_retire: state=%0d count=%0d", state, instr_count); else passed++;
    instr = I_JR; mem_ready = 1'b1;
    tick(); mem_ready = 1'b0;
    checks++; if ({pc_we, pc_src, reg_we} !== {1'b1, 2'b11, 1'b0})
      $display("FAIL jr_decode: pc_we=%b pc_src=%b reg_we=%b", pc_we, pc_src, reg_we);
    else passed++;
    tick();
    checks++; if ({state, instr_count} !== {3'd1, 32'd6}) $display("FAIL jr_retire: state=%0d count=%0d", state, instr_count); else passed++;
  endtask

  task automatic test_immediates();
    instr = I_ORI; mem_ready = 1'b1;
    tick(); mem_ready = 1'b0; tick();
    checks++; if ({alu_ctrl, alu_src_b, ext_zero} !== {4'b0001, 1'b1, 1'b1})
      $display("FAIL ori_exec: alu=%b srcb=%b zext=%b", alu_ctrl, alu_src_b, ext_zero);
    else passed++;
    tick();
    checks++; if ({state, reg_we, reg_dst} !== {3'd5, 1'b1, 2'b00}) $display("FAIL ori_wb: state=%0d reg_we=%b dst=%b", state, reg_we, reg_dst); else passed++;
    tick();
    instr = I_ADDI; mem_ready = 1'b1;
    tick(); mem_ready = 1'b0; tick(); tick();
    checks++; if ({state, reg_we} !== {3'd5, 1'b0}) $display("FAIL addi_r0_wb: state=%0d reg_we=%b", state, reg_we); else passed++;
    tick();
    checks++; if ({state, instr_count} !== {3'd1, 32'd8}) $display("FAIL addi_retire: state=%0d count=%0d", state, instr_count); else passed++;
  endtask

  task automatic test_mem_boundary();
    instr = I_SW; mem_ready = 1'b1;
    tick(); mem_ready = 1'b0; tick(); tick();
    checks++; if ({state, dmem_req, dmem_we} !== {3'd4, 2'b11}) $display("FAIL sw_mem: state=%0d dreq=%b dwe=%b", state, dmem_req, dmem_we); else passed++;
    repeat (15) tick();
    checks++; if (state !== 3'd4) $display("FAIL sw_wait15: state=%0d want 4", state); else passed++;
    mem_ready = 1'b1;
    tick(); mem_ready = 1'b0;
    checks++; if ({state, instr_count} !== {3'd1, 32'd9}) $display("FAIL sw_late_ready: state=%0d count=%0d", state, instr_count); else passed++;
  endtask

  task automatic test_illegal();
    instr = I_BAD; mem_ready = 1'b1;
    tick(); mem_ready = 1'b0; tick();
    checks++; if ({state, illegal, busy, imem_req, instr_count} !== {3'd7, 1'b1, 2'b00, 32'd9})
      $display("FAIL illegal_trap: state=%0d illegal=%b busy=%b count=%0d", state, illegal, busy, instr_count);
    else passed++;
    start = 1'b1; tick(); tick(); start = 1'b0;
    checks++; if ({state, illegal} !== {3'd7, 1'b1}) $display("FAIL error_sticky: state=%0d illegal=%b", state, illegal); else passed++;
    rst_n = 1'b0; #1;
    checks++; if ({state, illegal, instr_count} !== {3'd0, 1'b0, 32'd0})
      $display("FAIL error_reset: state=%0d illegal=%b count=%0d", state, illegal, instr_count);
    else passed++;
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_mem();
    instr = I_SW; mem_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    checks++; if ({state, instr_count} !== {3'd1, 32'd1}) $display("FAIL sw_retire: state=%0d count=%0d", state, instr_count); else passed++;
    tick(); mem_ready = 1'b0; tick(); tick();
    checks++; if ({state, dmem_req, dmem_we} !== {3'd4, 2'b11}) $display("FAIL sw2_mem: state=%0d dreq=%b dwe=%b", state, dmem_req, dmem_we); else passed++;
    #2 rst_n = 1'b0; #1;
    checks++; if ({state, dmem_req, dmem_we, busy, instr_count} !== {3'd0, 3'b000, 32'd0})
      $display("FAIL reset_mid_mem: state=%0d dreq=%b dwe=%b count=%0d", state, dmem_req, dmem_we, instr_count);
    else passed++;
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    instr = I_ADD; mem_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    checks++; if ({state, imem_req} !== {3'd1, 1'b1}) $display("FAIL tmo_fetch: state=%0d imem=%b", state, imem_req); else passed++;
    repeat (15) tick();
    checks++; if (state !== 3'd1) $display("FAIL tmo_cycle15: state=%0d want 1", state); else passed++;
    tick();
    checks++; if ({state, busy, illegal, imem_req} !== {3'd7, 3'b000})
      $display("FAIL tmo_error: state=%0d busy=%b illegal=%b imem=%b", state, busy, illegal, imem_req);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_beq();
    test_jumps();
    test_immediates();
    test_mem_boundary();
    test_illegal();
    test_reset_mid_mem();
    test_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
